// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared backend types for the MMU command/response interface.
//   - bp_be_mem_op_e              : memory operation encoding; unlisted codes are non-memory ops
//   - bp_be_exception_s           : illegal_instr, load_misaligned, store_misaligned
//   - bp_be_mmu_cmd_s             : mem_op, addr, data
//   - bp_be_mmu_resp_s            : data, exception
//   - bp_be_mmu_scratchpad_state_e: response-path states of the scratchpad responder
package bp_be_pkg;

    localparam int dword_width_p = 64;
    localparam int vaddr_width_p = 64;

    typedef enum logic [3:0] {
        e_lb  = 4'd0,
        e_lh  = 4'd1,
        e_lw  = 4'd2,
        e_ld  = 4'd3,
        e_lbu = 4'd4,
        e_lhu = 4'd5,
        e_lwu = 4'd6,
        e_sb  = 4'd8,
        e_sh  = 4'd9,
        e_sw  = 4'd10,
        e_sd  = 4'd11
    } bp_be_mem_op_e;

    typedef struct packed {
        logic illegal_instr;
        logic load_misaligned;
        logic store_misaligned;
    } bp_be_exception_s;

    typedef struct packed {
        bp_be_mem_op_e              mem_op;
        logic [vaddr_width_p-1:0]   addr;
        logic [dword_width_p-1:0]   data;
    } bp_be_mmu_cmd_s;

    typedef struct packed {
        logic [dword_width_p-1:0]   data;
        bp_be_exception_s           exception;
    } bp_be_mmu_resp_s;

    localparam int bp_be_mmu_cmd_width  = $bits(bp_be_mmu_cmd_s);
    localparam int bp_be_mmu_resp_width = $bits(bp_be_mmu_resp_s);

    typedef enum logic [1:0] {
        e_idle  = 2'd0,
        e_resp  = 2'd1,
        e_stall = 2'd2
    } bp_be_mmu_scratchpad_state_e;

endpackage

// File: rtl/bsg_mem_1rw_sync_mask_write_byte.sv
// bsg_mem_1rw_sync_mask_write_byte: single-port synchronous RAM with byte write mask.
//   clk_i        : clock
//   v_i          : access enable (read when w_i=0, write when w_i=1)
//   w_i          : write select
//   addr_i       : word index
//   data_i       : write data
//   write_mask_i : one bit per byte of data_i
//   data_o       : read data, registered; holds its value until the next read
module bsg_mem_1rw_sync_mask_write_byte #(
    parameter  int width_p       = 64,
    parameter  int els_p         = 512,
    localparam int addr_width_lp = $clog2(els_p),
    localparam int mask_width_lp = width_p / 8
) (
    input  logic                     clk_i,
    input  logic                     v_i,
    input  logic                     w_i,
    input  logic [addr_width_lp-1:0] addr_i,
    input  logic [width_p-1:0]       data_i,
    input  logic [mask_width_lp-1:0] write_mask_i,
    output logic [width_p-1:0]       data_o
);

    // NOTE: the array and read register have no reset; a RAM cannot be cleared in one cycle
    // and software never relies on its power-up contents.
    logic [width_p-1:0] mem_q [els_p];
    logic [width_p-1:0] data_q;

    // NOTE: non-blocking assignments keep read-before-write ordering identical in simulation
    // and in the synthesized flops.
    always_ff @(posedge clk_i) begin
        if (v_i & w_i) begin
            for (int b = 0; b < mask_width_lp; b++) begin
                if (write_mask_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= data_i[8*b +: 8];
                end
            end
        end
        if (v_i & ~w_i) begin
            data_q <= mem_q[addr_i];
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bp_be_mmu_scratchpad.sv
// bp_be_mmu_scratchpad: memory-side responder for the backend MMU interface, backed by a
// byte-maskable 64-bit scratchpad. One command per cycle in, exactly one response out, in order.
//   clk_i, reset_i            : clock, synchronous active-high reset
//   mmu_cmd_i / _v_i / _ready_o  : command channel (mem_op, addr, data)
//   mmu_resp_o / _v_o / _ready_i : response channel (data, exception)
// Build option: BP_BE_MMU_SCRATCHPAD_MISALIGN_CHECK_EN raises misaligned exceptions instead of
// silently forcing natural alignment.
module bp_be_mmu_scratchpad
    import bp_be_pkg::*;
#(
    parameter  int els_p     = 512,
    localparam int lg_els_lp = $clog2(els_p)
) (
    input  logic                            clk_i,
    input  logic                            reset_i,
    input  logic [bp_be_mmu_cmd_width-1:0]  mmu_cmd_i,
    input  logic                            mmu_cmd_v_i,
    output logic                            mmu_cmd_ready_o,
    output logic [bp_be_mmu_resp_width-1:0] mmu_resp_o,
    output logic                            mmu_resp_v_o,
    input  logic                            mmu_resp_ready_i
);

    function automatic logic is_load(bp_be_mem_op_e op);
        return op inside {e_lb, e_lh, e_lw, e_ld, e_lbu, e_lhu, e_lwu};
    endfunction

    function automatic logic is_store(bp_be_mem_op_e op);
        return op inside {e_sb, e_sh, e_sw, e_sd};
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] lg_size(bp_be_mem_op_e op);
        case (op)
            e_lb, e_lbu, e_sb: return 2'd0;
            e_lh, e_lhu, e_sh: return 2'd1;
            e_lw, e_lwu, e_sw: return 2'd2;
            default:           return 2'd3;
        endcase
    endfunction

    // offset bits that must be zero for a naturally aligned access
    function automatic logic [2:0] align_bits(logic [1:0] lg);
        case (lg)
            2'd0:    return 3'b000;
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b111;
        endcase
    endfunction

    function automatic logic [7:0] byte_mask(logic [1:0] lg);
        case (lg)
            2'd0:    return 8'h01;
            2'd1:    return 8'h03;
            2'd2:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    // word already shifted so the accessed bytes sit at bit 0
    function automatic logic [63:0] extend(logic [63:0] w, bp_be_mem_op_e op);
        case (op)
            e_lb:    return {{56{w[7]}},  w[7:0]};
            e_lbu:   return {56'b0,       w[7:0]};
            e_lh:    return {{48{w[15]}}, w[15:0]};
            e_lhu:   return {48'b0,       w[15:0]};
            e_lw:    return {{32{w[31]}}, w[31:0]};
            e_lwu:   return {32'b0,       w[31:0]};
            default: return w;
        endcase
    endfunction

    bp_be_mmu_cmd_s              cmd;
    bp_be_mmu_resp_s             resp_formed, hold_q, hold_d;
    bp_be_mmu_scratchpad_state_e state_q, state_d;
    bp_be_mem_op_e               op_q;
    logic [2:0]                  off_q;
    logic                        misaligned_q;

    logic                        accept;
    logic [1:0]                  cmd_lg;
    logic [2:0]                  cmd_off;
    logic                        cmd_misaligned;
    logic                        ram_v;
    logic [63:0]                 ram_data_lo;
    logic [63:0]                 word_shifted;
    logic                        unused_addr;

    assign cmd         = mmu_cmd_i;
    assign unused_addr = ^cmd.addr[vaddr_width_p-1:3+lg_els_lp];
    assign cmd_lg      = lg_size(cmd.mem_op);

`ifdef BP_BE_MMU_SCRATCHPAD_MISALIGN_CHECK_EN
    assign cmd_off        = cmd.addr[2:0];
    assign cmd_misaligned = |(cmd.addr[2:0] & align_bits(cmd_lg));
`else
    assign cmd_off        = cmd.addr[2:0] & ~align_bits(cmd_lg);
    assign cmd_misaligned = 1'b0;
`endif

    // Ready is held low in e_stall so a store can never clobber the RAM read register
    // before a stalled load has been captured.
    assign mmu_cmd_ready_o = ~reset_i
                           & ((state_q == e_idle) | ((state_q == e_resp) & mmu_resp_ready_i));
    assign accept          = mmu_cmd_v_i & mmu_cmd_ready_o;
    assign ram_v           = accept & (is_load(cmd.mem_op) | is_store(cmd.mem_op)) & ~cmd_misaligned;

    bsg_mem_1rw_sync_mask_write_byte #(
        .width_p (64),
        .els_p   (els_p)
    ) ram (
        .clk_i        (clk_i),
        .v_i          (ram_v),
        .w_i          (is_store(cmd.mem_op)),
        .addr_i       (cmd.addr[3 +: lg_els_lp]),
        .data_i       (cmd.data << {cmd_off, 3'b000}),
        .write_mask_i (byte_mask(cmd_lg) << cmd_off),
        .data_o       (ram_data_lo)
    );

    // Attributes of the accepted command needed to shape its response next cycle.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            op_q         <= cmd.mem_op;
            off_q        <= cmd_off;
            misaligned_q <= cmd_misaligned;
        end
    end

    assign word_shifted = ram_data_lo >> {off_q, 3'b000};

    always_comb begin
        resp_formed = '0;
        if (is_load(op_q)) begin
            resp_formed.exception.load_misaligned = misaligned_q;
            resp_formed.data = misaligned_q ? 64'b0 : extend(word_shifted, op_q);
        end else if (is_store(op_q)) begin
            resp_formed.exception.store_misaligned = misaligned_q;
        end else begin
            resp_formed.exception.illegal_instr = 1'b1;
        end
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        case (state_q)
            e_idle: begin
                if (accept) state_d = e_resp;
            end
            e_resp: begin
                if (mmu_resp_ready_i) begin
                    state_d = accept ? e_resp : e_idle;
                end else begin
                    state_d = e_stall;
                    hold_d  = resp_formed;
                end
            end
            e_stall: begin
                if (mmu_resp_ready_i) state_d = e_idle;
            end
            default: state_d = e_idle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= e_idle;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    assign mmu_resp_v_o = (state_q != e_idle);
    assign mmu_resp_o   = (state_q == e_resp) ? resp_formed : hold_q;

endmodule

// File: tb/tb_bp_be_mmu_scratchpad.sv
// Self-checking bench for bp_be_mmu_scratchpad: a directed vector table, hand-written
// handshake sequences (back-to-back, stall, reset while stalled) and randomized traffic,
// all compared against a byte-array reference model with an in-order response queue.
module tb_bp_be_mmu_scratchpad;
    import bp_be_pkg::*;

    localparam int ELS       = 512;
    localparam int MEM_BYTES = ELS * 8;

    logic            clk = 1'b0;
    logic            reset_i;
    bp_be_mmu_cmd_s  cmd_w;
    logic            cmd_v;
    logic            cmd_ready;
    bp_be_mmu_resp_s resp_w;
    logic            resp_v;
    logic            resp_ready;

    always #5 clk = ~clk;

    bp_be_mmu_scratchpad #(.els_p(ELS)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .mmu_cmd_i        (cmd_w),
        .mmu_cmd_v_i      (cmd_v),
        .mmu_cmd_ready_o  (cmd_ready),
        .mmu_resp_o       (resp_w),
        .mmu_resp_v_o     (resp_v),
        .mmu_resp_ready_i (resp_ready)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]      ref_mem [MEM_BYTES];
    bp_be_mmu_resp_s exp_q [$];
    logic            blocked = 1'b0;  // front response already shown once without being taken

    function automatic bp_be_mmu_resp_s model_exec(bp_be_mmu_cmd_s c);
        bp_be_mmu_resp_s r = '0;
        int sz = 0;
        bit ld = 0, sgn = 0;
        int ba;
        case (c.mem_op)
            e_lb:  begin sz = 1; ld = 1; sgn = 1; end
            e_lh:  begin sz = 2; ld = 1; sgn = 1; end
            e_lw:  begin sz = 4; ld = 1; sgn = 1; end
            e_ld:  begin sz = 8; ld = 1; end
            e_lbu: begin sz = 1; ld = 1; end
            e_lhu: begin sz = 2; ld = 1; end
            e_lwu: begin sz = 4; ld = 1; end
            e_sb:  sz = 1;
            e_sh:  sz = 2;
            e_sw:  sz = 4;
            e_sd:  sz = 8;
            default: sz = 0;
        endcase
        if (sz == 0) begin
            r.exception.illegal_instr = 1'b1;
            return r;
        end
        ba = int'(c.addr % MEM_BYTES);
`ifdef BP_BE_MMU_SCRATCHPAD_MISALIGN_CHECK_EN
        if (ba % sz != 0) begin
            if (ld) r.exception.load_misaligned = 1'b1;
            else    r.exception.store_misaligned = 1'b1;
            return r;
        end
`else
        ba = ba - (ba % sz);
`endif
        if (ld) begin
            for (int i = 0; i < sz; i++) r.data[8*i +: 8] = ref_mem[ba+i];
            if (sgn && r.data[8*sz-1]) begin
                for (int i = 8*sz; i < 64; i++) r.data[i] = 1'b1;
            end
        end else begin
            for (int i = 0; i < sz; i++) ref_mem[ba+i] = c.data[8*i +: 8];
        end
        return r;
    endfunction

    // One clock cycle: drive inputs 1 ns after the edge, check 1 ns later, advance the model.
    task automatic cycle(input logic v, input bp_be_mmu_cmd_s c, input logic rr, input logic rst);
        logic exp_ready;
        @(posedge clk);
        #1;
        reset_i    = rst;
        cmd_w      = c;
        cmd_v      = v;
        resp_ready = rr;
        #1;
        exp_ready = !rst && ((exp_q.size() == 0) || (rr && !blocked));
        check("cmd_ready", 128'(cmd_ready), 128'(exp_ready));
        if (rst) begin
            exp_q.delete();
            blocked = 1'b0;
            return;
        end
        check("resp_v", 128'(resp_v), 128'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("resp", 128'(resp_w), 128'(exp_q[0]));
            if (rr) begin
                void'(exp_q.pop_front());
                blocked = 1'b0;
            end else begin
                blocked = 1'b1;
            end
        end
        if (v && exp_ready) exp_q.push_back(model_exec(c));
    endtask

    function automatic bp_be_mmu_cmd_s mk(bp_be_mem_op_e op, logic [63:0] a, logic [63:0] d);
        bp_be_mmu_cmd_s c;
        c.mem_op = op;
        c.addr   = a;
        c.data   = d;
        return c;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        bp_be_mem_op_e    op;
        logic [63:0]      addr;
        logic [63:0]      data;
        logic [63:0]      exp_data;
        bp_be_exception_s exp_exc;
    } vec_t;

    vec_t tbl [$];

    localparam bp_be_exception_s EX_NONE = 3'b000;
    localparam bp_be_exception_s EX_ILL  = 3'b100;
    localparam bp_be_exception_s EX_LMIS = 3'b010;
    localparam bp_be_exception_s EX_SMIS = 3'b001;

    function automatic void add(bp_be_mem_op_e op, logic [63:0] a, logic [63:0] d,
                                logic [63:0] ed, bp_be_exception_s ee);
        vec_t t;
        t.op = op; t.addr = a; t.data = d; t.exp_data = ed; t.exp_exc = ee;
        tbl.push_back(t);
    endfunction

    bp_be_mmu_cmd_s nop_c;

    initial begin
        nop_c      = '0;
        reset_i    = 1'b1;
        cmd_w      = '0;
        cmd_v      = 1'b0;
        resp_ready = 1'b1;

        add(e_sd,  64'h10, 64'h8877665544332211, 64'h0, EX_NONE);
        add(e_lb,  64'h17, 64'h0, 64'hFFFFFFFFFFFFFF88, EX_NONE);
        add(e_lbu, 64'h17, 64'h0, 64'h0000000000000088, EX_NONE);
        add(e_sd,  64'h20, 64'h0706050403020100, 64'h0, EX_NONE);
        add(e_sw,  64'h24, 64'h00000000DEADBEEF, 64'h0, EX_NONE);
        add(e_lw,  64'h24, 64'h0, 64'hFFFFFFFFDEADBEEF, EX_NONE);
        add(e_lwu, 64'h24, 64'h0, 64'h00000000DEADBEEF, EX_NONE);
        add(e_lwu, 64'h20, 64'h0, 64'h0000000003020100, EX_NONE);
        add(e_ld,  64'h20, 64'h0, 64'hDEADBEEF03020100, EX_NONE);
        add(e_sd,  64'h30, 64'h112233445566F788, 64'h0, EX_NONE);
`ifdef BP_BE_MMU_SCRATCHPAD_MISALIGN_CHECK_EN
        add(e_lh,  64'h31, 64'h0, 64'h0, EX_LMIS);
`else
        add(e_lh,  64'h31, 64'h0, 64'hFFFFFFFFFFFFF788, EX_NONE);
`endif
        add(e_lhu, 64'h32, 64'h0, 64'h0000000000005566, EX_NONE);
        add(bp_be_mem_op_e'(4'hF), 64'h10, 64'hFFFFFFFFFFFFFFFF, 64'h0, EX_ILL);
        add(e_ld,  64'h10, 64'h0, 64'h8877665544332211, EX_NONE);
        add(e_sd,  64'h40, 64'h0, 64'h0, EX_NONE);
        add(e_sb,  64'h43, 64'h123456789ABCDEAB, 64'h0, EX_NONE);
        add(e_ld,  64'h1040, 64'h0, 64'h00000000AB000000, EX_NONE);
`ifdef BP_BE_MMU_SCRATCHPAD_MISALIGN_CHECK_EN
        add(e_sh,  64'h45, 64'h000000000000CAFE, 64'h0, EX_SMIS);
        add(e_ld,  64'h40, 64'h0, 64'h00000000AB000000, EX_NONE);
`else
        add(e_sh,  64'h45, 64'h000000000000CAFE, 64'h0, EX_NONE);
        add(e_ld,  64'h40, 64'h0, 64'h0000CAFEAB000000, EX_NONE);
`endif

        // Reset with a valid command present: nothing may be accepted.
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(e_sd, 64'h10, 64'h0), 1'b1, 1'b1);
        cycle(1'b0, nop_c, 1'b1, 1'b0);
        check("reset_resp", 128'(resp_w), 128'(0));

        // Directed table, one command at a time.
        foreach (tbl[k]) begin
            cycle(1'b1, mk(tbl[k].op, tbl[k].addr, tbl[k].data), 1'b1, 1'b0);
            cycle(1'b0, nop_c, 1'b1, 1'b0);
            check($sformatf("tbl%0d_data", k), 128'(resp_w.data), 128'(tbl[k].exp_data));
            check($sformatf("tbl%0d_exc", k), 128'(resp_w.exception), 128'(tbl[k].exp_exc));
        end

        // Back-to-back loads, one per cycle.
        cycle(1'b1, mk(e_ld,  64'h10, 64'h0), 1'b1, 1'b0);
        cycle(1'b1, mk(e_lbu, 64'h11, 64'h0), 1'b1, 1'b0);
        cycle(1'b1, mk(e_lw,  64'h24, 64'h0), 1'b1, 1'b0);
        cycle(1'b1, mk(e_lhu, 64'h30, 64'h0), 1'b1, 1'b0);
        cycle(1'b0, nop_c, 1'b1, 1'b0);

        // Stall for five cycles with a command waiting, then release.
        cycle(1'b1, mk(e_ld, 64'h10, 64'h0), 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b1, mk(e_sd, 64'h10, 64'h0), 1'b0, 1'b0);
        cycle(1'b1, mk(e_sd, 64'h10, 64'h0), 1'b1, 1'b0);
        cycle(1'b1, mk(e_lw, 64'h20, 64'h0), 1'b1, 1'b0);
        cycle(1'b0, nop_c, 1'b1, 1'b0);

        // Reset while stalled on a store: response dropped, store kept.
        cycle(1'b1, mk(e_sd, 64'h50, 64'hA5A5_0123_4567_89AB), 1'b0, 1'b0);
        cycle(1'b0, nop_c, 1'b0, 1'b0);
        cycle(1'b0, nop_c, 1'b0, 1'b0);
        cycle(1'b1, mk(e_ld, 64'h10, 64'h0), 1'b0, 1'b1);
        cycle(1'b0, nop_c, 1'b1, 1'b0);
        check("post_reset_resp", 128'(resp_w), 128'(0));
        cycle(1'b1, mk(e_ld, 64'h50, 64'h0), 1'b1, 1'b0);
        cycle(1'b0, nop_c, 1'b1, 1'b0);

        // Randomized traffic over 16 initialized words, with aliasing upper address bits.
        for (int w = 0; w < 16; w++) begin
            cycle(1'b1, mk(e_sd, 64'(w * 8), {$urandom, $urandom}), 1'b1, 1'b0);
        end
        for (int n = 0; n < 400; n++) begin
            bp_be_mem_op_e op;
            logic [63:0]   a;
            int            r = $urandom_range(0, 11);
            case (r)
                0: op = e_lb;  1: op = e_lh;  2: op = e_lw;  3: op = e_ld;
                4: op = e_lbu; 5: op = e_lhu; 6: op = e_lwu; 7: op = e_sb;
                8: op = e_sh;  9: op = e_sw; 10: op = e_sd;
                default: op = bp_be_mem_op_e'(($urandom % 2 == 0) ? 4'd7 : 4'd14);
            endcase
            a       = {$urandom, $urandom};
            a[11:3] = 9'($urandom_range(0, 15));
            cycle(($urandom % 4) != 0, mk(op, a, {$urandom, $urandom}), ($urandom % 4) != 0, 1'b0);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, nop_c, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
